// File: rtl/sar_adc_controller.sv
// MSB-first successive-approximation ADC controller: each bit waits SETTLE_CYCLES+SYNC_STAGES cycles, then takes one decide cycle.
// Define SAR_CONTINUOUS_EN to add the cont input, which re-arms the conversion straight from DONE.
module sar_adc_controller #(
  parameter int N_BITS        = 8,
  parameter int SETTLE_CYCLES = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
`ifdef SAR_CONTINUOUS_EN
  input  logic              cont,
`endif
  input  logic              comp_in,
  output logic [N_BITS-1:0] dac_code,
  output logic              busy,
  output logic              done,
  output logic [N_BITS-1:0] result
);
  localparam int W     = SETTLE_CYCLES + SYNC_STAGES;
  localparam int CNT_W = $clog2(W + 1);
  localparam int IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(W - 1);
  localparam logic [IDX_W-1:0]  IDX_TOP  = IDX_W'(N_BITS - 1);
  localparam logic [N_BITS-1:0] MSB_ONLY = {1'b1, {(N_BITS-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SETTLE, DECIDE, DONE} state_t;

  state_t             state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic               comp_sync;
  logic [N_BITS-1:0]  code, decided;
  logic [IDX_W-1:0]   idx, idx_dn;
  logic [CNT_W-1:0]   cnt;
  logic               restart;

`ifdef SAR_CONTINUOUS_EN
  assign restart = cont;
`else
  assign restart = 1'b0;
`endif

  // Free-running synchronizer; the settle wait already covers its delay.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], comp_in};
  end
  assign comp_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETTLE;
      SETTLE:  if (cnt == CNT_LAST) state_nxt = DECIDE;
      DECIDE:  state_nxt = (idx == '0) ? DONE : SETTLE;
      DONE:    state_nxt = restart ? SETTLE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign idx_dn = idx - 1'b1;

  always_comb begin
    decided = code;
    if (!comp_sync) decided[idx] = 1'b0;
    if (idx != '0)  decided[idx_dn] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      code   <= '0;
      idx    <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          code <= MSB_ONLY;
          idx  <= IDX_TOP;
          cnt  <= '0;
        end
        SETTLE: cnt <= cnt + 1'b1;
        DECIDE: begin
          code <= decided;
          cnt  <= '0;
          if (idx != '0) idx    <= idx_dn;
          else           result <= decided;
        end
        DONE: if (restart) begin
          code <= MSB_ONLY;
          idx  <= IDX_TOP;
          cnt  <= '0;
        end
        default: ;
      endcase
    end
  end

  // The DAC sits at zero whenever no conversion is in flight.
  always_comb begin
    dac_code = (state == IDLE) ? '0 : code;
    busy     = (state != IDLE);
    done     = (state == DONE);
  end
endmodule

// File: tb/tb_sar_adc_controller.sv
// Bench for sar_adc_controller: ideal comparator driven from vin, cycle-level model of the conversion timeline, directed scenarios.
// Continuous-mode scenario is compiled only with SAR_CONTINUOUS_EN.
module tb_sar_adc_controller;
  localparam int N    = 8;
  localparam int W    = 18;
  localparam int STEP = W + 1;
  localparam int CONV = N * STEP;

  logic         clk = 1'b0;
  logic         reset, start, comp_in;
  logic         cont = 1'b0;
  logic [N-1:0] dac_code, result;
  logic         busy, done;

  logic [7:0]   vin = 8'h00;
  logic         glitch_en = 1'b0;
  logic         tog = 1'b0;
  logic         chk_en = 1'b0;
  logic         win;
  int           checks = 0;
  int           errors = 0;

  logic         m_active = 1'b0;
  int           m_cyc = 0;
  logic [7:0]   m_res = 8'h00;

  logic [7:0]   t1_seq [8] = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

  sar_adc_controller dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
`ifdef SAR_CONTINUOUS_EN
    .cont     (cont),
`endif
    .comp_in  (comp_in),
    .dac_code (dac_code),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  // Comparator: ideal, except toggling outside each bit's settled decide window when glitch_en is set.
  always @(posedge clk) tog <= ~tog;
  assign win     = m_active && ((m_cyc % STEP) >= 14);
  assign comp_in = (glitch_en && !win) ? tog : (vin >= dac_code);

  // After k resolved bits an ideal SAR holds the top k bits of vin, plus the next trial bit.
  function automatic logic [7:0] trial(input logic [7:0] v, input int k);
    int keep;
    int t;
    keep = N - k;
    t = (int'(v) >> keep) << keep;
    return 8'(t | (128 >> k));
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_active <= 1'b0;
      m_cyc    <= 0;
      m_res    <= 8'h00;
    end else if (m_active) begin
      if (m_cyc == CONV) begin
        if (cont) m_cyc <= 0;
        else      m_active <= 1'b0;
      end else begin
        m_cyc <= m_cyc + 1;
        if (m_cyc == CONV - 1) m_res <= vin;
      end
    end else if (start) begin
      m_active <= 1'b1;
      m_cyc    <= 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (m_active) begin
        chk("busy", {31'b0, busy}, 32'd1);
        if (m_cyc < CONV) begin
          chk("dac_code", {24'b0, dac_code}, {24'b0, trial(vin, m_cyc / STEP)});
          chk("done", {31'b0, done}, 32'd0);
        end else begin
          chk("dac_code", {24'b0, dac_code}, {24'b0, vin});
          chk("done", {31'b0, done}, 32'd1);
        end
      end else begin
        chk("busy", {31'b0, busy}, 32'd0);
        chk("dac_code", {24'b0, dac_code}, 32'd0);
        chk("done", {31'b0, done}, 32'd0);
      end
      chk("result", {24'b0, result}, {24'b0, m_res});
    end
  end

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < budget);
    chk("done_seen", {31'b0, done}, 32'd1);
  endtask

  task automatic run_conv(input logic [7:0] v);
    vin   = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(CONV + 20);
    chk("conv_result", {24'b0, result}, {24'b0, v});
    @(negedge clk);
    @(negedge clk);
  endtask

`ifdef SAR_CONTINUOUS_EN
  int tcount = 0;
  always @(posedge clk) tcount <= tcount + 1;
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_dac", {24'b0, dac_code}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_result", {24'b0, result}, 32'd0);
    chk_en = 1'b1;
    reset  = 1'b0;
    @(negedge clk);

    // Single conversion of 0xA5 against literal trial sequence and timing.
    vin   = 8'hA5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c <= CONV + 1; c++) begin
      if ((c % STEP) == 0 && c < CONV) chk("t1_trial", {24'b0, dac_code}, {24'b0, t1_seq[c / STEP]});
      if (c == CONV) begin
        chk("t1_done", {31'b0, done}, 32'd1);
        chk("t1_result", {24'b0, result}, 32'h0000_00A5);
      end
      if (c == CONV + 1) chk("t1_busy_drop", {31'b0, busy}, 32'd0);
      @(negedge clk);
    end

    run_conv(8'h00);
    run_conv(8'hFF);

    // start pulses mid-conversion are ignored; start in first idle cycle is accepted.
    vin   = 8'h3C;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (89) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(CONV + 20);
    chk("t3_result", {24'b0, result}, 32'h0000_003C);
    @(negedge clk);
    chk("t3_idle", {31'b0, busy}, 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t3_restart_busy", {31'b0, busy}, 32'd1);
    chk("t3_restart_dac", {24'b0, dac_code}, 32'h0000_0080);
    wait_done(CONV + 20);
    chk("t3_result2", {24'b0, result}, 32'h0000_003C);
    @(negedge clk);

    // Reset during a conversion.
    vin   = 8'h77;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (60) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t4_dac", {24'b0, dac_code}, 32'd0);
    chk("t4_busy", {31'b0, busy}, 32'd0);
    chk("t4_result", {24'b0, result}, 32'd0);
    chk("t4_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    run_conv(8'h5A);

    // Comparator glitching outside the decide window.
    glitch_en = 1'b1;
    run_conv(8'h81);
    glitch_en = 1'b0;

`ifdef SAR_CONTINUOUS_EN
    begin
      int t1;
      int t2;
      cont  = 1'b1;
      vin   = 8'h42;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(CONV + 20);
      t1 = tcount;
      chk("t6_result1", {24'b0, result}, 32'h0000_0042);
      wait_done(CONV + 20);
      t2 = tcount;
      chk("t6_gap", t2 - t1, CONV + 1);
      chk("t6_result2", {24'b0, result}, 32'h0000_0042);
      repeat (50) @(negedge clk);
      cont = 1'b0;
      wait_done(CONV + 20);
      chk("t6_result3", {24'b0, result}, 32'h0000_0042);
      @(negedge clk);
      chk("t6_idle", {31'b0, busy}, 32'd0);
      @(negedge clk);
    end
`endif

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sar_adc_controller.md
Name: sar_adc_controller

Overview:
Successive-approximation controller for the board-level SAR ADC.
- Drives the DAC trial code and samples the external analog comparator, which is asynchronous to clk.
- The comparator is passed through an internal SYNC_STAGES-deep flop synchronizer.
- Resolves one bit per step, MSB first, and presents the final code with a one-cycle done pulse.
- Sits between the sample-request logic (timer or user control) and the DAC/comparator pins.

Parameters:
N_BITS  8  conversion resolution; width of dac_code and result
SETTLE_CYCLES  16  clk cycles allowed for the DAC and comparator to settle after each trial-code change
SYNC_STAGES  2  flop stages in the comparator synchronizer (minimum 2)

Ports:
clk  input  1  system clock
reset  input  1  reset, synchronous, active-high
start  input  1  conversion request; sampled only in IDLE
comp_in  input  1  raw asynchronous comparator output; 1 = analog input >= DAC voltage
dac_code  output  N_BITS  trial code driven to the DAC
busy  output  1  high from the start-accept edge until the DONE cycle ends
done  output  1  one-cycle pulse; result valid and updated in this cycle
result  output  N_BITS  last completed conversion; held until the next done

Behaviour:
- Reset values (all synchronous): state=IDLE, dac_code=0, busy=0, done=0, result=0, synchronizer flops=0, counters=0.
- Synchronizer: comp_sync = comp_in delayed by SYNC_STAGES flops. It is free-running, except that reset clears it.
- Definition: W = SETTLE_CYCLES + SYNC_STAGES, the wait per bit. This guarantees comp_sync reflects the settled comparator.
- IDLE:
  - dac_code=0, busy=0.
  - On start=1: load bit index i=N_BITS-1 and trial=1<<(N_BITS-1). Set dac_code=trial, busy=1, clear settle counter, go to SETTLE.
- SETTLE:
  - Counter increments each cycle.
  - After exactly W cycles in SETTLE, go to DECIDE.
- DECIDE (1 cycle), sample comp_sync:
  - If comp_sync=0, clear bit i of the code.
  - If i>0: set bit i-1, decrement i, clear the counter, go to SETTLE.
  - If i=0: go to DONE.
- DONE (1 cycle):
  - result = final code; done=1; dac_code holds the final code; busy=1.
  - Next cycle: IDLE, busy=0.
  - DONE always returns to IDLE first. A start held continuously therefore begins the next conversion on the first IDLE cycle.
- Latency: done is high in the cycle beginning N_BITS*(W+1) edges after the edge that sampled start. With defaults this is 8*19 = 152.
- start while busy=1: ignored, with no queuing.
- Reset mid-conversion: immediate return to IDLE. The partial code is discarded, result is cleared to 0, and no done pulse is issued.
- comp_in glitching outside the DECIDE sample window has no effect on the code.
- Arithmetic: only single-bit set/clear on an N_BITS register, so overflow is impossible. Result range is 0..2^N_BITS-1.

Optional Feature:
Macro: SAR_CONTINUOUS_EN.
- Defined:
  - Adds input port cont (1 bit), placed after start.
  - While cont=1, DONE transitions directly to SETTLE with trial=1<<(N_BITS-1), and busy stays 1.
  - Back-to-back done pulses are spaced N_BITS*(W+1)+1 cycles apart (153 at defaults).
  - Deasserting cont lets the current conversion finish normally, then the block returns to IDLE.
- Not defined: no cont port; behaviour exactly as above.

Test Plan:
1. Comparator model comp_in=(vin>=dac_code), vin=0xA5, single start pulse:
   - dac_code steps 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5, each trial held 19 cycles.
   - done at cycle 152 with result=0xA5; busy drops the following cycle.
2. vin=0x00 then vin=0xFF:
   - Results 0x00 and 0xFF.
   - No X on dac_code and no extra done pulses.
3. start re-pulsed at cycles 10 and 100 of a running conversion (vin=0x3C):
   - Ignored; exactly one done, result=0x3C.
   - A start in the first IDLE cycle after done starts a new conversion.
4. reset asserted at cycle 60 of a conversion:
   - Next cycle dac_code=0, busy=0, result=0, no done.
   - A subsequent start with vin=0x5A yields 0x5A.
5. comp_in toggled every cycle except a stable window covering SETTLE end through DECIDE (vin=0x81):
   - Result 0x81, showing that only the synchronized, settled sample matters.
6. With SAR_CONTINUOUS_EN and cont=1, vin=0x42:
   - done pulses 153 cycles apart, each result=0x42.
   - cont dropped mid-conversion: that conversion completes, then IDLE.
